// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: multi-cycle mult/div with architectural HI/LO.
// The full result is computed at launch; the busy countdown only models latency.
module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_E,
    input  logic [2:0]  MDU_Op_E,
    input  logic [31:0] FRead_Data_1_E,
    input  logic [31:0] FRead_Data_2_E,
    input  logic        Flush_E,
    output logic        Busy_E,
    output logic [31:0] HI_E,
    output logic [31:0] LO_E
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] MULT_N = 16'(MULT_CYCLES);
    localparam logic [15:0] DIV_N  = 16'(DIV_CYCLES);

    state_t      state, state_next;
    logic [15:0] cnt;
    logic [31:0] hi, lo, pend_hi, pend_lo;
    logic        pend_valid;

    logic        is_mult, is_div, launch;
    logic        neg_a, neg_b;
    logic [31:0] abs_a, abs_b, uq, ur, quot, rem;
    logic [63:0] prod;
    logic [31:0] calc_hi, calc_lo;
    logic        calc_valid;

    // Request handshake: Start_E is a single-cycle request, taken only while
    // Busy_E is low; requests seen while Busy_E is high are dropped, so the
    // hazard unit must stall the instruction until Busy_E falls.
    assign is_mult = (MDU_Op_E == 3'b000) || (MDU_Op_E == 3'b001);
    assign is_div  = (MDU_Op_E == 3'b010) || (MDU_Op_E == 3'b011);
    assign launch  = Start_E && (state == IDLE) && (is_mult || is_div);

    always_comb begin
        prod = 64'd0;
        if (MDU_Op_E == 3'b000)
            prod = $signed({{32{FRead_Data_1_E[31]}}, FRead_Data_1_E}) *
                   $signed({{32{FRead_Data_2_E[31]}}, FRead_Data_2_E});
        else if (MDU_Op_E == 3'b001)
            prod = {32'd0, FRead_Data_1_E} * {32'd0, FRead_Data_2_E};

        // Sign-magnitude division keeps min/-1 well defined and
        // truncates toward zero with the remainder following the dividend.
        neg_a = (MDU_Op_E == 3'b010) && FRead_Data_1_E[31];
        neg_b = (MDU_Op_E == 3'b010) && FRead_Data_2_E[31];
        abs_a = neg_a ? -FRead_Data_1_E : FRead_Data_1_E;
        abs_b = (FRead_Data_2_E == 32'd0) ? 32'd1 :
                (neg_b ? -FRead_Data_2_E : FRead_Data_2_E);
        uq    = abs_a / abs_b;
        ur    = abs_a % abs_b;
        quot  = (neg_a ^ neg_b) ? -uq : uq;
        rem   = neg_a ? -ur : ur;

        calc_hi    = prod[63:32];
        calc_lo    = prod[31:0];
        calc_valid = 1'b1;
        if (is_div) begin
            calc_hi    = rem;
            calc_lo    = quot;
            calc_valid = (FRead_Data_2_E != 32'd0);
        end
    end

    always_comb begin
        state_next = state;
        if (Flush_E)
            state_next = IDLE;
        else begin
            case (state)
                IDLE:    if (launch) state_next = BUSY;
                BUSY:    if (cnt == 16'd1) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            pend_hi    <= 32'd0;
            pend_lo    <= 32'd0;
            pend_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (Flush_E) begin
                cnt        <= 16'd0;
                pend_hi    <= 32'd0;
                pend_lo    <= 32'd0;
                pend_valid <= 1'b0;
            end else if (state == IDLE) begin
                if (launch) begin
                    cnt        <= is_mult ? MULT_N : DIV_N;
                    pend_hi    <= calc_hi;
                    pend_lo    <= calc_lo;
                    pend_valid <= calc_valid;
                end else if (Start_E && MDU_Op_E == 3'b100)
                    hi <= FRead_Data_1_E;
                else if (Start_E && MDU_Op_E == 3'b101)
                    lo <= FRead_Data_1_E;
            end else begin
                cnt <= cnt - 16'd1;
                if (cnt == 16'd1 && pend_valid) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end

    assign Busy_E = (state == BUSY);
    assign HI_E   = hi;
    assign LO_E   = lo;

endmodule

// File: doc/mdu_e.md
MDU_E -- requirements
Module: mdu_e

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, giving the number of Busy cycles for mult/multu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, giving the number of Busy cycles for div/divu.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-low reset (reset==0 at a rising edge resets).
REQ-005 SHALL provide port Start_E, input, 1 bit: the E-stage instruction is an MDU operation this cycle.
REQ-006 SHALL provide port MDU_Op_E, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are no-op.
REQ-007 SHALL provide port FRead_Data_1_E, input, 32 bits: forwarded rs value (dividend, multiplicand, or mthi/mtlo source).
REQ-008 SHALL provide port FRead_Data_2_E, input, 32 bits: forwarded rt value (divisor or multiplier).
REQ-009 SHALL provide port Flush_E, input, 1 bit: cancels any operation in flight.
REQ-010 SHALL provide port Busy_E, output, 1 bit: a mult/div is in progress.
REQ-011 SHALL provide port HI_E, output, 32 bits: architectural HI, read by mfhi and passed toward the ALU_OUT_M path.
REQ-012 SHALL provide port LO_E, output, 32 bits: architectural LO, read by mflo.

Function
REQ-013 SHALL implement two states, IDLE and BUSY, with Busy_E==1 exactly when the state is BUSY; all outputs SHALL be registered.
REQ-014 In IDLE, Start_E=1 with a mult-class op at edge t SHALL latch the operands, compute the full result into pending registers, load the counter with MULT_CYCLES, and enter BUSY.
REQ-015 In IDLE, Start_E=1 with a div-class op at edge t SHALL do the same as REQ-014, loading the counter with DIV_CYCLES.
REQ-016 In BUSY, each edge SHALL decrement the counter; the edge at which the counter equals 1 SHALL commit pending HI/LO and return to IDLE.
REQ-017 Busy_E SHALL therefore be high for exactly N cycles (t+1 .. t+N), and new HI/LO SHALL be visible in the first cycle Busy_E is low.
REQ-018 HI_E and LO_E SHALL hold their old values throughout BUSY; no partial results are visible.
REQ-019 mult/multu SHALL write HI = product[63:32] and LO = product[31:0], computed as 64-bit signed or unsigned respectively.
REQ-020 div/divu SHALL write LO = quotient and HI = remainder; the signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-022 A divisor of 0 SHALL still run DIV_CYCLES of Busy_E and then leave HI/LO unchanged.
REQ-023 mthi/mtlo with Start_E=1 in IDLE SHALL update HI (resp. LO) at that edge, without entering BUSY.
REQ-024 Start_E while in BUSY SHALL be ignored, and the state SHALL not change; the hazard unit stalls such instructions.
REQ-025 Start_E with op 110/111 SHALL have no effect.
REQ-026 Flush_E=1 at an edge SHALL return to IDLE, clear the counter, discard pending results, and leave HI/LO unchanged.
REQ-027 Flush_E SHALL take priority over Start_E and over a commit occurring at the same edge.
REQ-028 Implementations SHALL NOT use combinational paths from inputs to outputs.

Reset
REQ-029 reset==0 at an edge SHALL force IDLE, counter=0, Busy_E=0, HI_E=0, LO_E=0, and pending registers=0, overriding all other inputs.
REQ-030 Reset asserted mid-operation SHALL discard the operation, with no HI/LO commit at that edge.

Verification
REQ-031 mult 0xFFFFFFFF x 0x00000002 -> Busy_E high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE.
REQ-032 multu 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE; divu 7/2 -> Busy_E high for 10 cycles, then LO=3, HI=1.
REQ-033 div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 mthi 0x12345678, then div 5/0 -> HI stays 0x12345678 after 10 Busy cycles; mtlo during BUSY is ignored.
REQ-035 Start a div, assert Flush_E on its 3rd Busy cycle -> Busy_E=0 next cycle and HI/LO unchanged; Flush_E together with Start_E -> no operation started.
REQ-036 Start a mult, drive reset=0 on its 2nd Busy cycle -> Busy_E=0, HI=0, LO=0 next cycle; an immediate new mult then completes normally.
